frame_pixel_counter: RTL and testbench

Per-frame pixel statistics engine that feeds the AGC lookup-table selector. Counts pixels whose luma is at or below a programmable threshold across one video frame, framed by start/end strobes. Publishes the count as `pix_num` with a one-cycle valid pulse at frame end. `pix_num` is held stable for the whole following frame so the LUT selector sees a constant value.

---
 rtl/frame_pixel_counter.sv | 85 ++++++++
 tb/tb_frame_pixel_counter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/frame_pixel_counter.sv
// frame_pixel_counter: counts pixels at or below a luma threshold per frame and publishes the count at frame end
//
// Ports:
//   clk, rst     - rising-edge clock, asynchronous active-high reset
//   frame_start  - strobe in the cycle before a frame's first pixel
//   frame_end    - strobe coincident with or after the last pixel
//   pix_valid    - pix_data is valid this cycle
//   pix_data     - unsigned luma sample
//   pix_num      - dark-pixel count of the last completed frame, held for the next frame
//   num_valid    - one-cycle pulse when pix_num updates
//   busy         - high while a frame is being counted
//   frame_err    - one-cycle pulse on a malformed frame; tied to 0 unless FRAME_CHECK_EN is defined
//
// Optional feature: define FRAME_CHECK_EN to compare the total pixel count
// against FRAME_PIXELS at frame end and to flag aborted frames.
module frame_pixel_counter #(
  parameter int BIT_WIDTH = 21,
  parameter int PIX_W = 8,
  parameter int PIX_TH = 64
`ifdef FRAME_CHECK_EN
  , parameter int FRAME_PIXELS = 2073600
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_start,
  input  logic                 frame_end,
  input  logic                 pix_valid,
  input  logic [PIX_W-1:0]     pix_data,
  output logic [BIT_WIDTH-1:0] pix_num,
  output logic                 num_valid,
  output logic                 busy,
  output logic                 frame_err
);
  localparam logic [PIX_W-1:0] TH = PIX_W'(PIX_TH);
  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;
  state_t state, state_nxt;
  logic [BIT_WIDTH-1:0] dcnt;
  logic count_en, publish;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_nxt;
  end
  // frame_start wins over everything, including a coincident frame_end
  always_comb begin
    state_nxt = frame_start ? COUNT :
                (state == COUNT && frame_end) ? DONE :
                (state == COUNT) ? COUNT : IDLE;
  end
  // a pixel on the frame_start cycle belongs to no frame and is dropped
  always_comb begin
    busy = state == COUNT;
    count_en = state == COUNT && pix_valid && !frame_start;
    publish = state == DONE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dcnt <= '0;
    else if (frame_start) dcnt <= '0;
    else if (count_en && pix_data <= TH && dcnt != '1) dcnt <= dcnt + 1'b1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_num <= '0;
      num_valid <= 1'b0;
    end else begin
      num_valid <= publish;
      if (publish) pix_num <= dcnt;
    end
  end
`ifdef FRAME_CHECK_EN
  logic [BIT_WIDTH-1:0] tcnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tcnt <= '0;
    else if (frame_start) tcnt <= '0;
    else if (count_en && tcnt != '1) tcnt <= tcnt + 1'b1;
  end
  // error rises with num_valid on a length mismatch, or one cycle after an abort
  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_err <= 1'b0;
    else frame_err <= (state == COUNT && frame_start) || (publish && int'(tcnt) != FRAME_PIXELS);
  end
`else
  assign frame_err = 1'b0;
`endif
endmodule

// File: tb/tb_frame_pixel_counter.sv
// tb_frame_pixel_counter: scoreboard bench for frame_pixel_counter with a wide and a 4-bit saturating instance
module tb_frame_pixel_counter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_start = 1'b0, frame_end = 1'b0, pix_valid = 1'b0;
  logic [7:0] pix_data = '0;
  logic [20:0] pix_num_a;
  logic [3:0] pix_num_b;
  logic num_valid_a, num_valid_b, busy_a, busy_b, frame_err_a, frame_err_b;
  int checks = 0, errors = 0, err_a = 0, err_b = 0, ea, eb;
  int q_a[$], q_b[$];
  always #5 clk = ~clk;
  frame_pixel_counter #(
`ifdef FRAME_CHECK_EN
    .FRAME_PIXELS(16),
`endif
    .BIT_WIDTH(21), .PIX_W(8), .PIX_TH(64)
  ) dut_a (
    .clk(clk), .rst(rst), .frame_start(frame_start), .frame_end(frame_end),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_num(pix_num_a),
    .num_valid(num_valid_a), .busy(busy_a), .frame_err(frame_err_a)
  );
  frame_pixel_counter #(
`ifdef FRAME_CHECK_EN
    .FRAME_PIXELS(16),
`endif
    .BIT_WIDTH(4), .PIX_W(8), .PIX_TH(64)
  ) dut_b (
    .clk(clk), .rst(rst), .frame_start(frame_start), .frame_end(frame_end),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_num(pix_num_b),
    .num_valid(num_valid_b), .busy(busy_b), .frame_err(frame_err_b)
  );
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic cyc(input logic fs, input logic fe, input logic pv, input logic [7:0] d);
    frame_start = fs;
    frame_end = fe;
    pix_valid = pv;
    pix_data = d;
    @(posedge clk);
    #1;
  endtask
  task automatic expect_frame(input int a, input int b);
    q_a.push_back(a);
    q_b.push_back(b);
  endtask
  always @(negedge clk) begin
    if (num_valid_a) begin
      checks++;
      if (q_a.size() == 0) begin
        errors++;
        $display("FAIL pix_num_a: unexpected num_valid with %0d", pix_num_a);
      end else begin
        ea = q_a.pop_front();
        if (int'(pix_num_a) != ea) begin
          errors++;
          $display("FAIL pix_num_a: got %0d expected %0d", pix_num_a, ea);
        end
      end
    end
    if (num_valid_b) begin
      checks++;
      if (q_b.size() == 0) begin
        errors++;
        $display("FAIL pix_num_b: unexpected num_valid with %0d", pix_num_b);
      end else begin
        eb = q_b.pop_front();
        if (int'(pix_num_b) != eb) begin
          errors++;
          $display("FAIL pix_num_b: got %0d expected %0d", pix_num_b, eb);
        end
      end
    end
    if (frame_err_a) err_a++;
    if (frame_err_b) err_b++;
  end
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset pix_num", int'(pix_num_a), 0);
    chk("reset num_valid", int'(num_valid_a), 0);
    chk("reset busy", int'(busy_a), 0);
    chk("reset frame_err", int'(frame_err_a), 0);
    cyc(0, 1, 1, 8'd0);
    cyc(0, 0, 0, 8'd0);
    // frame 1: ramp 0..240 step 16, five samples <= 64
    cyc(1, 0, 0, 8'd0);
    @(negedge clk);
    chk("busy after start", int'(busy_a), 1);
    expect_frame(5, 5);
    for (int i = 0; i < 16; i++) cyc(0, i == 15, 1, 8'(i * 16));
    @(negedge clk);
    chk("busy drops after end", int'(busy_a), 0);
    chk("num_valid latency", int'(num_valid_a), 0);
    cyc(0, 0, 0, 8'd0);
    cyc(0, 0, 0, 8'd0);
    // frame 2: bright frame, single dark pixel coincident with frame_end
    cyc(1, 0, 0, 8'd0);
    expect_frame(1, 1);
    for (int i = 0; i < 16; i++) cyc(0, i == 15, 1, i == 15 ? 8'd0 : 8'd255);
    cyc(0, 0, 0, 8'd0);
    cyc(0, 0, 0, 8'd0);
    // abort: 8 dark discarded, restart (pixel on start cycle dropped), 3 dark
    cyc(1, 0, 0, 8'd0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 8'd0);
    cyc(1, 0, 1, 8'd0);
    expect_frame(3, 3);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 8'd0);
    cyc(0, 1, 0, 8'd0);
    cyc(0, 0, 0, 8'd0);
    cyc(0, 0, 0, 8'd0);
    // saturation: 20 dark pixels, 4-bit instance clamps to 15
    cyc(1, 0, 0, 8'd0);
    expect_frame(20, 15);
    for (int i = 0; i < 20; i++) cyc(0, i == 19, 1, 8'd0);
    cyc(0, 0, 0, 8'd0);
    cyc(0, 0, 0, 8'd0);
    // reset mid-frame: nothing published, pix_num cleared
    cyc(1, 0, 0, 8'd0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 8'd0);
    rst = 1'b1;
    #2 rst = 1'b0;
    cyc(0, 1, 1, 8'd0);
    repeat (3) cyc(0, 0, 0, 8'd0);
    @(negedge clk);
    chk("reset pix_num_a", int'(pix_num_a), 0);
    chk("reset pix_num_b", int'(pix_num_b), 0);
    chk("reset busy", int'(busy_a), 0);
    chk("reset no num_valid", int'(num_valid_a), 0);
    // back-to-back: second frame_start lands in the DONE cycle
    cyc(1, 0, 0, 8'd0);
    expect_frame(16, 15);
    for (int i = 0; i < 16; i++) cyc(0, i == 15, 1, 8'd10);
    cyc(1, 0, 1, 8'd0);
    @(negedge clk);
    chk("b2b busy", int'(busy_a), 1);
    expect_frame(4, 4);
    for (int i = 0; i < 16; i++) cyc(0, i == 15, 1, i < 4 ? 8'd64 : 8'd65);
    repeat (4) cyc(0, 0, 0, 8'd0);
    @(negedge clk);
    chk("pending results a", q_a.size(), 0);
    chk("pending results b", q_b.size(), 0);
`ifdef FRAME_CHECK_EN
    chk("frame_err pulses a", err_a, 3);
`else
    chk("frame_err pulses a", err_a, 0);
    chk("frame_err pulses b", err_b, 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
